vga_rx_monitor: RTL and testbench

- Receive-side counterpart of the VGA timing generator: samples hsync/vsync/RGB on the pixel clock and recovers pixel coordinates.
- Checks timing against the 640x480 mode, tracks lock, and presents pixels with a valid strobe.
- Sits on the generator's output pins inside the top-level and the bench; used for self-check and for frame capture.

---
 rtl/vga_rx_monitor.sv | 166 ++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_monitor.sv
// Receive-side VGA monitor: recovers pixel coordinates from hsync/vsync, checks line/frame
// timing against the configured mode, tracks lock and strobes valid active pixels.
module vga_rx_monitor #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned LOCK_FRAMES = 2,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int unsigned HW      = $clog2(2 * H_TOTAL + 1),
    localparam int unsigned VW      = $clog2(2 * V_TOTAL + 1),
    localparam int unsigned XW      = $clog2(H_ACTIVE),
    localparam int unsigned YW      = $clog2(V_ACTIVE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hsync,
    input  logic          vsync,
    input  logic [3:0]    red,
    input  logic [3:0]    green,
    input  logic [3:0]    blue,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [11:0]   pix_rgb,
    output logic          pix_valid,
    output logic          frame_start,
    output logic          h_err,
    output logic          v_err,
    output logic          locked,
    output logic [15:0]   err_count
);

    localparam int unsigned GW = $clog2(LOCK_FRAMES + 1);

    localparam logic [HW-1:0] P_SAT   = HW'(2 * H_TOTAL);
    localparam logic [HW-1:0] P_END   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] P_SYNC  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_START = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_STOP  = HW'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [VW-1:0] L_SAT   = VW'(2 * V_TOTAL);
    localparam logic [VW-1:0] L_SYNC  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_START = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_STOP  = VW'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [VW:0]   V_TOT_W = (VW + 1)'(V_TOTAL);
    localparam logic [GW-1:0] G_LOCK  = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   good_q, good_d;
    logic            err_since_q, err_since_d;
    logic            hs_d, vs_d, h_seen;
    logic [HW-1:0]   p_q, p_n;
    logic [VW-1:0]   l_q, l_n;
    logic            hs_fall, hs_rise, vs_fall, vs_rise;
    logic            p_sat_evt, l_sat_evt, h_err_n, v_err_n, active;
    logic [16:0]     cnt_sum;

    assign hs_fall = ~hsync & hs_d;
    assign hs_rise = hsync & ~hs_d;
    assign vs_fall = ~vsync & vs_d;
    assign vs_rise = vsync & ~vs_d;

    always_comb begin
        p_n = p_q;
        if (hs_fall)             p_n = '0;
        else if (p_q != P_SAT)   p_n = p_q + HW'(1);
        l_n = l_q;
        if (vs_fall)                       l_n = '0;
        else if (hs_fall && l_q != L_SAT)  l_n = l_q + VW'(1);

        p_sat_evt = (p_n == P_SAT) && (p_q != P_SAT);
        l_sat_evt = (l_n == L_SAT) && (l_q != L_SAT);

        h_err_n = (hs_fall && h_seen && p_q != P_END) || (hs_rise && p_n != P_SYNC) || p_sat_evt;
        // Frame length is only meaningful once a previous vs_fall has been seen.
        v_err_n = (vs_fall && state_q != StSearch &&
                   (({1'b0, l_q} + {{VW{1'b0}}, hs_fall}) != V_TOT_W)) ||
                  (vs_rise && l_n != L_SYNC) || l_sat_evt;

        active = (p_n >= H_START) && (p_n < H_STOP) && (l_n >= V_START) && (l_n < V_STOP);
        cnt_sum = {1'b0, err_count} + {16'd0, h_err_n} + {16'd0, v_err_n};
    end

    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        err_since_d = err_since_q;
        if (p_sat_evt || l_sat_evt) begin
            state_d     = StSearch;
            good_d      = '0;
            err_since_d = 1'b0;
        end else begin
            unique case (state_q)
                StSearch: begin
                    if (vs_fall) begin
                        state_d     = StTrack;
                        good_d      = '0;
                        err_since_d = 1'b0;
                    end
                end
                StTrack, StLocked: begin
                    if (h_err_n || v_err_n) begin
                        state_d     = StTrack;
                        good_d      = '0;
                        // An error on the vs_fall itself belongs to the frame that just ended.
                        err_since_d = ~vs_fall;
                    end else if (vs_fall) begin
                        err_since_d = 1'b0;
                        if (state_q == StTrack && !err_since_q) begin
                            good_d = good_q + GW'(1);
                            if (good_d == G_LOCK) state_d = StLocked;
                        end
                    end
                end
                default: state_d = StSearch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StSearch;
            good_q      <= '0;
            err_since_q <= 1'b0;
            hs_d        <= 1'b1;
            vs_d        <= 1'b1;
            h_seen      <= 1'b0;
            p_q         <= '0;
            l_q         <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
            locked      <= 1'b0;
            err_count   <= '0;
        end else begin
            state_q     <= state_d;
            good_q      <= good_d;
            err_since_q <= err_since_d;
            hs_d        <= hsync;
            vs_d        <= vsync;
            h_seen      <= h_seen | hs_fall;
            p_q         <= p_n;
            l_q         <= l_n;
            pix_x       <= XW'(p_n - H_START);
            pix_y       <= YW'(l_n - V_START);
            pix_rgb     <= {red, green, blue};
            pix_valid   <= active && (state_d == StLocked);
            frame_start <= vs_fall;
            h_err       <= h_err_n;
            v_err       <= v_err_n;
            locked      <= (state_d == StLocked);
            err_count   <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a scaled-down video mode so whole frames stay short.
module tb_vga_rx_monitor;

    localparam int H_ACT = 16, H_FP = 4, H_SY = 6, H_BP = 6;
    localparam int V_ACT = 8, V_FP = 2, V_SY = 2, V_BP = 3;
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;  // 32
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;  // 15
    localparam int H_ST = H_SY + H_BP;                  // 12
    localparam int V_ST = V_SY + V_BP;                  // 5
    localparam int XW = $clog2(H_ACT);
    localparam int YW = $clog2(V_ACT);

    logic clk = 1'b0;
    logic rst, hsync, vsync;
    logic [3:0] red, green, blue;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [11:0] pix_rgb;
    logic pix_valid, frame_start, h_err, v_err, locked;
    logic [15:0] err_count;

    int n_checks = 0, n_pass = 0;
    int hcnt, vcnt, fscnt, valid_cnt, map_bad;
    int he_p, he_l, ve_p, ve_l;
    logic he_lk, lk0;
    logic [XW-1:0] c0_x, c1_x;
    logic [YW-1:0] c0_y, c1_y;
    logic [11:0] c0_rgb;
    logic c0_v, c1_v, c2_v, c3_v;
    logic [15:0] exp_ec;

    always #5 clk = ~clk;

    vga_rx_monitor #(
        .H_ACTIVE(H_ACT), .H_FRONT(H_FP), .H_SYNC(H_SY), .H_BACK(H_BP),
        .V_ACTIVE(V_ACT), .V_FRONT(V_FP), .V_SYNC(V_SY), .V_BACK(V_BP),
        .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .pix_valid(pix_valid),
        .frame_start(frame_start), .h_err(h_err), .v_err(v_err),
        .locked(locked), .err_count(err_count)
    );

    // One sample; outputs observed #1 after the edge belong to this sample.
    task automatic drive(input logic hs, input logic vs, input int p, input int l);
        logic [11:0] rgb;
        rgb = 12'(p);
        hsync = hs; vsync = vs; {red, green, blue} = rgb;
        @(posedge clk); #1;
        if (h_err) begin hcnt++; he_p = p; he_l = l; he_lk = locked; end
        if (v_err) begin vcnt++; ve_p = p; ve_l = l; end
        if (frame_start) fscnt++;
        if (pix_valid) begin
            valid_cnt++;
            if (pix_x !== XW'(p - H_ST) || pix_y !== YW'(l - V_ST) || pix_rgb !== rgb) map_bad++;
        end
        if (l == 0 && p == 0) lk0 = locked;
        if (l == V_ST && p == H_ST) begin c0_x = pix_x; c0_y = pix_y; c0_rgb = pix_rgb; c0_v = pix_valid; end
        if (l == V_ST + V_ACT - 1 && p == H_ST + H_ACT - 1) begin c1_x = pix_x; c1_y = pix_y; c1_v = pix_valid; end
        if (l == V_ST + V_ACT - 1 && p == H_ST + H_ACT) c2_v = pix_valid;
        if (l == V_ST - 1 && p == H_ST) c3_v = pix_valid;
    endtask

    task automatic send_line(input int l, input int vs_low, input int len, input int hs_low);
        for (int p = 0; p < len; p++) drive(p >= hs_low, l >= vs_low, p, l);
    endtask

    task automatic send_frame(input int nlines, input int vs_low, input int bad_line,
                              input int bad_len, input int bad_hs);
        for (int l = 0; l < nlines; l++) begin
            if (l == bad_line) send_line(l, vs_low, bad_len, bad_hs);
            else send_line(l, vs_low, H_TOT, H_SY);
        end
    endtask

    task automatic normal_frame();
        send_frame(V_TOT, V_SY, -1, H_TOT, H_SY);
    endtask

    task automatic clear_counts();
        hcnt = 0; vcnt = 0; fscnt = 0; valid_cnt = 0; map_bad = 0;
        he_p = -1; he_l = -1; ve_p = -1; ve_l = -1; he_lk = 1'bx;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, -1, -1);
        drive(1'b1, 1'b1, -1, -1);
        n_checks++;
        if ({pix_x, pix_y, pix_rgb, pix_valid, frame_start, h_err, v_err, locked, err_count} !== '0)
            $display("FAIL reset_outputs: got x=%0d y=%0d rgb=%h v=%b fs=%b he=%b ve=%b lk=%b ec=%0d want all 0",
                     pix_x, pix_y, pix_rgb, pix_valid, frame_start, h_err, v_err, locked, err_count);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_ideal_lock();
        clear_counts();
        normal_frame();
        normal_frame();
        n_checks++; if (lk0 !== 1'b0) $display("FAIL ideal_lk_vs2: got %b want 0", lk0); else n_pass++;
        normal_frame();
        n_checks++; if (lk0 !== 1'b1) $display("FAIL ideal_lk_vs3: got %b want 1", lk0); else n_pass++;
        normal_frame();
        n_checks++; if (locked !== 1'b1) $display("FAIL ideal_locked: got %b want 1", locked); else n_pass++;
        n_checks++; if (hcnt + vcnt != 0) $display("FAIL ideal_errs: got h=%0d v=%0d want 0", hcnt, vcnt); else n_pass++;
        n_checks++; if (err_count !== 16'd0) $display("FAIL ideal_err_count: got %0d want 0", err_count); else n_pass++;
        n_checks++; if (fscnt != 4) $display("FAIL ideal_frame_start: got %0d want 4", fscnt); else n_pass++;
    endtask

    task automatic test_pixel_map();
        clear_counts();
        normal_frame();
        n_checks++;
        if ({c0_v, c0_x, c0_y, c0_rgb} !== {1'b1, XW'(0), YW'(0), 12'(H_ST)})
            $display("FAIL map_first: got v=%b x=%0d y=%0d rgb=%h want v=1 x=0 y=0 rgb=%h",
                     c0_v, c0_x, c0_y, c0_rgb, 12'(H_ST));
        else n_pass++;
        n_checks++;
        if ({c1_v, c1_x, c1_y} !== {1'b1, XW'(H_ACT - 1), YW'(V_ACT - 1)})
            $display("FAIL map_last: got v=%b x=%0d y=%0d want v=1 x=%0d y=%0d",
                     c1_v, c1_x, c1_y, H_ACT - 1, V_ACT - 1);
        else n_pass++;
        n_checks++; if (c2_v !== 1'b0) $display("FAIL map_past_right: got %b want 0", c2_v); else n_pass++;
        n_checks++; if (c3_v !== 1'b0) $display("FAIL map_above_top: got %b want 0", c3_v); else n_pass++;
        n_checks++;
        if (valid_cnt != H_ACT * V_ACT) $display("FAIL map_valid_count: got %0d want %0d", valid_cnt, H_ACT * V_ACT);
        else n_pass++;
        n_checks++; if (map_bad != 0) $display("FAIL map_coords: got %0d bad samples want 0", map_bad); else n_pass++;
    endtask

    task automatic test_long_line();
        clear_counts();
        send_frame(V_TOT, V_SY, 5, H_TOT + 1, H_SY);
        exp_ec = exp_ec + 16'd1;
        n_checks++;
        if (hcnt != 1 || he_l != 6 || he_p != 0)
            $display("FAIL long_line_herr: got n=%0d at l=%0d p=%0d want n=1 at l=6 p=0", hcnt, he_l, he_p);
        else n_pass++;
        n_checks++; if (he_lk !== 1'b0) $display("FAIL long_line_unlock: got %b want 0", he_lk); else n_pass++;
        n_checks++; if (err_count !== exp_ec) $display("FAIL long_line_count: got %0d want %0d", err_count, exp_ec); else n_pass++;
        normal_frame();
        normal_frame();
        n_checks++; if (locked !== 1'b0) $display("FAIL long_line_early_lock: got %b want 0", locked); else n_pass++;
        normal_frame();
        n_checks++; if (lk0 !== 1'b1) $display("FAIL long_line_relock: got %b want 1", lk0); else n_pass++;
        n_checks++; if (hcnt != 1 || vcnt != 0) $display("FAIL long_line_extra: got h=%0d v=%0d want 1 0", hcnt, vcnt); else n_pass++;
    endtask

    task automatic test_short_hsync();
        clear_counts();
        send_frame(V_TOT, V_SY, 5, H_TOT, H_SY - 1);
        exp_ec = exp_ec + 16'd1;
        n_checks++;
        if (hcnt != 1 || he_l != 5 || he_p != H_SY - 1)
            $display("FAIL short_hsync: got n=%0d at l=%0d p=%0d want n=1 at l=5 p=%0d", hcnt, he_l, he_p, H_SY - 1);
        else n_pass++;
        n_checks++; if (locked !== 1'b0) $display("FAIL short_hsync_lock: got %b want 0", locked); else n_pass++;
        n_checks++; if (err_count !== exp_ec) $display("FAIL short_hsync_count: got %0d want %0d", err_count, exp_ec); else n_pass++;
    endtask

    task automatic test_long_vsync();
        clear_counts();
        send_frame(V_TOT, V_SY + 1, -1, H_TOT, H_SY);
        exp_ec = exp_ec + 16'd1;
        n_checks++;
        if (vcnt != 1 || ve_l != V_SY + 1 || ve_p != 0 || hcnt != 0)
            $display("FAIL long_vsync: got v=%0d at l=%0d p=%0d h=%0d want v=1 at l=%0d p=0 h=0",
                     vcnt, ve_l, ve_p, hcnt, V_SY + 1);
        else n_pass++;
        n_checks++; if (err_count !== exp_ec) $display("FAIL long_vsync_count: got %0d want %0d", err_count, exp_ec); else n_pass++;
    endtask

    task automatic test_long_frame();
        clear_counts();
        send_frame(V_TOT + 1, V_SY, -1, H_TOT, H_SY);
        n_checks++; if (vcnt != 0) $display("FAIL long_frame_early: got %0d want 0", vcnt); else n_pass++;
        normal_frame();
        exp_ec = exp_ec + 16'd1;
        n_checks++;
        if (vcnt != 1 || ve_l != 0 || ve_p != 0)
            $display("FAIL long_frame_verr: got n=%0d at l=%0d p=%0d want n=1 at l=0 p=0", vcnt, ve_l, ve_p);
        else n_pass++;
        n_checks++; if (err_count !== exp_ec) $display("FAIL long_frame_count: got %0d want %0d", err_count, exp_ec); else n_pass++;
    endtask

    task automatic test_hsync_lost();
        normal_frame();
        normal_frame();
        n_checks++; if (locked !== 1'b1) $display("FAIL lost_prelock: got %b want 1", locked); else n_pass++;
        clear_counts();
        send_line(5, V_SY, H_TOT, H_SY);
        for (int i = 0; i < 3 * H_TOT; i++) drive(1'b1, 1'b1, H_TOT + i, 5);
        exp_ec = exp_ec + 16'd1;
        n_checks++;
        if (hcnt != 1 || he_p != 2 * H_TOT || vcnt != 0)
            $display("FAIL lost_herr: got h=%0d at p=%0d v=%0d want h=1 at p=%0d v=0", hcnt, he_p, vcnt, 2 * H_TOT);
        else n_pass++;
        n_checks++; if (he_lk !== 1'b0 || locked !== 1'b0) $display("FAIL lost_unlock: got %b/%b want 0/0", he_lk, locked); else n_pass++;
        n_checks++; if (err_count !== exp_ec) $display("FAIL lost_count: got %0d want %0d", err_count, exp_ec); else n_pass++;
        // In SEARCH the wrong-length frame is not judged; only the late hs_fall is.
        clear_counts();
        normal_frame();
        exp_ec = exp_ec + 16'd1;
        n_checks++;
        if (hcnt != 1 || vcnt != 0) $display("FAIL search_unchecked: got h=%0d v=%0d want 1 0", hcnt, vcnt);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        send_line(0, V_SY, H_TOT, H_SY);
        send_line(1, V_SY, H_TOT, H_SY);
        for (int p = 0; p < 20; p++) drive(p >= H_SY, 1'b1, p, 2);
        n_checks++; if (err_count !== exp_ec) $display("FAIL pre_reset_count: got %0d want %0d", err_count, exp_ec); else n_pass++;
        rst = 1'b1;
        drive(1'b1, 1'b1, 20, 2);
        rst = 1'b0;
        n_checks++;
        if ({pix_x, pix_y, pix_rgb, pix_valid, frame_start, h_err, v_err, locked, err_count} !== '0)
            $display("FAIL mid_reset_outputs: got v=%b lk=%b ec=%0d x=%0d y=%0d rgb=%h want all 0",
                     pix_valid, locked, err_count, pix_x, pix_y, pix_rgb);
        else n_pass++;
        clear_counts();
        normal_frame();
        normal_frame();
        n_checks++; if (lk0 !== 1'b0) $display("FAIL mid_reset_lk_vs2: got %b want 0", lk0); else n_pass++;
        normal_frame();
        n_checks++; if (lk0 !== 1'b1) $display("FAIL mid_reset_lk_vs3: got %b want 1", lk0); else n_pass++;
        n_checks++;
        if (hcnt + vcnt != 0 || err_count !== 16'd0)
            $display("FAIL mid_reset_errs: got h=%0d v=%0d ec=%0d want 0 0 0", hcnt, vcnt, err_count);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; hsync = 1'b1; vsync = 1'b1; red = '0; green = '0; blue = '0;
        exp_ec = '0;
        clear_counts();
        test_reset();
        test_ideal_lock();
        test_pixel_map();
        test_long_line();
        test_short_hsync();
        test_long_vsync();
        test_long_frame();
        test_hsync_lost();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
